scr_arbiter_4: RTL and testbench

Round-robin arbiter and sequencer for the MCU's 8-bit scratch RAM, sharing the single scratch port among four requesters (e.g. register-file store, stack push/pop, interrupt context save, debug/DMA). It drives the 2-bit select of the existing 4:1 8-bit scratch data/address multiplexers plus the scratch write enable, and returns a one-cycle completion strobe to each requester. It sits between the requesters and the scratch RAM, which has a synchronous write and a one-cycle synchronous read.

---
 rtl/scr_arb_pkg.sv | 6 +
 rtl/rr_pick_4.sv | 20 ++
 rtl/scr_arbiter_4.sv | 69 ++++++
 tb/tb_scr_arbiter_4.sv | 104 ++++++++++
 4 files changed

// File: rtl/scr_arb_pkg.sv
// scr_arb_pkg: shared state encoding and widths for the scratch RAM arbiter
package scr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: round-robin picker; ports req (request mask), ptr (start index) -> valid, idx (first set req at ptr, ptr+1, ... mod 4)
module rr_pick_4
  import scr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);
  always_comb begin
    valid = 1'b0;
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        valid = 1'b1;
        idx = ptr + SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/scr_arbiter_4.sv
// scr_arbiter_4: round-robin scratch RAM arbiter/sequencer; ports clk, rst_n, req/we/lock (per requester) -> mux_sel, gnt, scr_we, ack, busy
module scr_arbiter_4
  import scr_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] we,
  input  logic [NUM_REQ-1:0] lock,
  output logic [SEL_W-1:0]   mux_sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               scr_we,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy
);
  state_t state;
  logic [SEL_W-1:0] ptr, pick_ptr, pick_idx, sel_n;
  logic [3:0] lock_cnt;
  logic [NUM_REQ-1:0] pick_req;
  logic idle, cmp, lock_go, pick_valid, load;
  assign idle = state == IDLE;
  assign cmp = (state == ACCESS && scr_we) || state == RDATA;
  assign lock_go = cmp && lock[mux_sel] && req[mux_sel] && ({1'b0, lock_cnt} + 5'd1 < 5'(MAX_LOCK));
  assign pick_req = idle ? req : req & ~gnt;
  assign pick_ptr = idle ? ptr : mux_sel + SEL_W'(1);
  assign load = (idle || (cmp && !lock_go)) && pick_valid;
  assign sel_n = lock_go ? mux_sel : pick_idx;
  assign busy = !idle;
  rr_pick_4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      lock_cnt <= '0;
      mux_sel <= '0;
      gnt <= '0;
      scr_we <= 1'b0;
      ack <= '0;
    end else begin
      if (cmp && !lock_go) begin
        ptr <= mux_sel + SEL_W'(1);
        lock_cnt <= '0;
      end
      if (lock_go) lock_cnt <= lock_cnt + 4'd1;
      if (load || lock_go) begin
        state <= ACCESS;
        mux_sel <= sel_n;
        gnt <= NUM_REQ'(1) << sel_n;
        scr_we <= we[sel_n];
        ack <= we[sel_n] ? NUM_REQ'(1) << sel_n : '0;
      end else if (state == ACCESS && !scr_we) begin
        state <= RDATA;
        ack <= gnt;
      end else if (cmp) begin
        state <= IDLE;
        gnt <= '0;
        scr_we <= 1'b0;
        ack <= '0;
      end
    end
  end
endmodule

// File: tb/tb_scr_arbiter_4.sv
// tb_scr_arbiter_4: directed table-driven bench for scr_arbiter_4
module tb_scr_arbiter_4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0, we = '0, lock = '0;
  logic [1:0] mux_sel;
  logic [3:0] gnt, ack;
  logic scr_we, busy;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[19];
  logic [3:0] creq[5];
  scr_arbiter_4 #(.MAX_LOCK(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .lock    (lock),
    .mux_sel (mux_sel),
    .gnt     (gnt),
    .scr_we  (scr_we),
    .ack     (ack),
    .busy    (busy)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] o(input logic [1:0] s, input logic [3:0] g, input logic w, input logic [3:0] a, input logic b);
    return {s, g, w, a, b};
  endfunction
  task automatic chk(input string nm, input logic [11:0] exp);
    n_chk++;
    if ({mux_sel, gnt, scr_we, ack, busy} !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel/gnt/we/ack/busy=%h expected %h", nm, {mux_sel, gnt, scr_we, ack, busy}, exp);
    end
  endtask
  initial begin
    tv[0]  = '{4'b0100, 4'b0100, 4'b0000, o(2, 4'b0100, 1, 4'b0100, 1)};
    tv[1]  = '{4'b0000, 4'b0000, 4'b0000, o(2, 4'b0000, 0, 4'b0000, 0)};
    tv[2]  = '{4'b1001, 4'b1001, 4'b0000, o(3, 4'b1000, 1, 4'b1000, 1)};
    tv[3]  = '{4'b0001, 4'b1001, 4'b0000, o(0, 4'b0001, 1, 4'b0001, 1)};
    tv[4]  = '{4'b0000, 4'b0000, 4'b0000, o(0, 4'b0000, 0, 4'b0000, 0)};
    tv[5]  = '{4'b0010, 4'b0000, 4'b0000, o(1, 4'b0010, 0, 4'b0000, 1)};
    tv[6]  = '{4'b0010, 4'b0000, 4'b0000, o(1, 4'b0010, 0, 4'b0010, 1)};
    tv[7]  = '{4'b0000, 4'b0000, 4'b0000, o(1, 4'b0000, 0, 4'b0000, 0)};
    tv[8]  = '{4'b0010, 4'b0010, 4'b0000, o(1, 4'b0010, 1, 4'b0010, 1)};
    tv[9]  = '{4'b0110, 4'b0110, 4'b0000, o(2, 4'b0100, 1, 4'b0100, 1)};
    tv[10] = '{4'b0010, 4'b0110, 4'b0000, o(1, 4'b0010, 1, 4'b0010, 1)};
    tv[11] = '{4'b0000, 4'b0000, 4'b0000, o(1, 4'b0000, 0, 4'b0000, 0)};
    tv[12] = '{4'b1001, 4'b1000, 4'b1000, o(3, 4'b1000, 1, 4'b1000, 1)};
    tv[13] = '{4'b1001, 4'b1000, 4'b1000, o(3, 4'b1000, 1, 4'b1000, 1)};
    tv[14] = '{4'b1001, 4'b1000, 4'b1000, o(3, 4'b1000, 1, 4'b1000, 1)};
    tv[15] = '{4'b1001, 4'b1000, 4'b1000, o(3, 4'b1000, 1, 4'b1000, 1)};
    tv[16] = '{4'b1001, 4'b1000, 4'b1000, o(0, 4'b0001, 0, 4'b0000, 1)};
    tv[17] = '{4'b0001, 4'b0000, 4'b0000, o(0, 4'b0001, 0, 4'b0001, 1)};
    tv[18] = '{4'b0000, 4'b0000, 4'b0000, o(0, 4'b0000, 0, 4'b0000, 0)};
    creq[0] = 4'b1111;
    creq[1] = 4'b1110;
    creq[2] = 4'b1100;
    creq[3] = 4'b1001;
    creq[4] = 4'b0011;
    #12;
    chk("reset", o(0, 4'b0000, 0, 4'b0000, 0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req = tv[i].req;
      we = tv[i].we;
      lock = tv[i].lock;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), tv[i].exp);
    end
    @(negedge clk);
    req = 4'b0100;
    we = 4'b0000;
    lock = 4'b0000;
    @(posedge clk);
    #1 chk("rst_read_addr", o(2, 4'b0100, 0, 4'b0000, 1));
    @(posedge clk);
    #1 chk("rst_read_data", o(2, 4'b0100, 0, 4'b0100, 1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", o(0, 4'b0000, 0, 4'b0000, 0));
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = creq[k];
      we = 4'b1111;
      @(posedge clk);
      #1 chk($sformatf("contend%0d", k), o(2'(k % 4), 4'b0001 << (k % 4), 1, 4'b0001 << (k % 4), 1));
    end
    @(negedge clk) req = 4'b0000;
    @(posedge clk);
    #1 chk("contend_idle", o(0, 4'b0000, 0, 4'b0000, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
